srt4_host_adapter: RTL and testbench

Request/response front-end for the `srt4` radix-4 divider core. It accepts one 8-bit dividend/divisor pair per transaction on a valid/ready request channel and serialises the pair onto the core's shared `inbus`/`beginSignal` protocol. It then collects quotient and remainder from `outbus` after `endSignal` and returns them on a valid/ready response channel. Divide-by-zero is handled locally, without involving the core.

---
 rtl/srt4_pkg.sv | 17 +
 rtl/srt4_host_adapter_if.sv | 27 ++
 rtl/srt4_adapter_watchdog.sv | 25 ++
 rtl/srt4_host_adapter.sv | 124 ++++++++++++
 tb/tb_srt4_host_adapter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/srt4_pkg.sv
// Shared constants and FSM state encoding for the srt4 divider host adapter.
package srt4_pkg;

  localparam int SRT4_WIDTH = 8;

  localparam logic [SRT4_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_DIVD,
    SEND_DIVS,
    WAIT_END,
    GET_REM,
    RESP
  } state_t;

endpackage

// File: rtl/srt4_host_adapter_if.sv
// Host-side request/response channels of the srt4 adapter.
// The master modport is the host; the slave modport is the adapter.
interface srt4_host_adapter_if;

  logic                            req_valid;
  logic                            req_ready;
  logic [srt4_pkg::SRT4_WIDTH-1:0] req_dividend;
  logic [srt4_pkg::SRT4_WIDTH-1:0] req_divisor;

  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [srt4_pkg::SRT4_WIDTH-1:0] rsp_quotient;
  logic [srt4_pkg::SRT4_WIDTH-1:0] rsp_remainder;
  logic                            rsp_div0;
  logic                            rsp_timeout;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div0, rsp_timeout
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div0, rsp_timeout
  );

endinterface

// File: rtl/srt4_adapter_watchdog.sv
// 8-bit clear/enable cycle counter; done flags the last permitted enabled cycle.
module srt4_adapter_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 8'd1;
  end

  // The count equals the number of enabled cycles already elapsed, so the
  // LIMIT-th enabled cycle is the one where the count reads LIMIT-1.
  assign done = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/srt4_host_adapter.sv
// Valid/ready front-end that serialises operands onto the srt4 core bus and returns results.
// Optional watchdog in WAIT_END enabled by defining SRT4_ADAPTER_TIMEOUT_EN.
module srt4_host_adapter
  import srt4_pkg::*;
#(
  parameter int WIDTH          = SRT4_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  srt4_host_adapter_if.slave host,
  output logic [WIDTH-1:0] core_inbus,
  output logic             core_begin,
  input  logic [WIDTH-1:0] core_outbus,
  input  logic             core_end
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit watchdog (1..255)");
  end

  state_t           state, next_state;
  logic [WIDTH-1:0] dividend, divisor;
  logic [WIDTH-1:0] quotient, remainder;
  logic             div0;
  logic             timeout;
  logic             wd_done;

`ifdef SRT4_ADAPTER_TIMEOUT_EN
  srt4_adapter_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst_b  (rst_b),
    .clear  (state == SEND_DIVS),
    .enable (state == WAIT_END),
    .done   (wd_done)
  );
`else
  assign wd_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets its default first so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (host.req_valid) next_state = (host.req_divisor == '0) ? RESP : SEND_DIVD;
      SEND_DIVD: next_state = SEND_DIVS;
      SEND_DIVS: next_state = WAIT_END;
      WAIT_END: begin
        if (core_end)     next_state = GET_REM;
        else if (wd_done) next_state = RESP;
      end
      GET_REM:   next_state = RESP;
      RESP:      if (host.rsp_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Operand and result registers; results only change outside RESP, so the
  // response fields hold steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dividend  <= '0;
      divisor   <= '0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (host.req_valid) begin
          dividend <= host.req_dividend;
          divisor  <= host.req_divisor;
          if (host.req_divisor == '0) begin
            quotient  <= DIV0_QUOTIENT;
            remainder <= host.req_dividend;
            div0      <= 1'b1;
          end
        end
        WAIT_END: begin
          if (core_end) begin
            quotient <= core_outbus;
          end else if (wd_done) begin
            quotient  <= '0;
            remainder <= '0;
            timeout   <= 1'b1;
          end
        end
        GET_REM: remainder <= core_outbus;
        RESP: if (host.rsp_ready) begin
          div0    <= 1'b0;
          timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    core_inbus = '0;
    case (state)
      SEND_DIVD: core_inbus = dividend;
      SEND_DIVS: core_inbus = divisor;
      default:   core_inbus = '0;
    endcase
  end

  assign core_begin         = (state == SEND_DIVD);
  assign host.req_ready     = (state == IDLE);
  assign host.rsp_valid     = (state == RESP);
  assign host.rsp_quotient  = quotient;
  assign host.rsp_remainder = remainder;
  assign host.rsp_div0      = div0;
`ifdef SRT4_ADAPTER_TIMEOUT_EN
  assign host.rsp_timeout   = timeout;
`else
  assign host.rsp_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_srt4_host_adapter.sv
// Directed plus randomized bench for srt4_host_adapter; the bench plays the srt4 core
// with an arithmetic divide model and a programmable completion latency.
module tb_srt4_host_adapter;
  import srt4_pkg::*;

  localparam int TMO = 16;

  logic       clk;
  logic       rst_b;
  logic [7:0] core_inbus;
  logic       core_begin;
  logic [7:0] core_outbus;
  logic       core_end;

  int n_checks = 0;
  int n_fail   = 0;

  srt4_host_adapter_if bus ();

  srt4_host_adapter #(.WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .host        (bus.slave),
    .core_inbus  (core_inbus),
    .core_begin  (core_begin),
    .core_outbus (core_outbus),
    .core_end    (core_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_core_begin"}, core_begin, 0);
    check({tag, "_core_inbus"}, core_inbus, 0);
    check({tag, "_quotient"}, bus.rsp_quotient, 0);
    check({tag, "_remainder"}, bus.rsp_remainder, 0);
    check({tag, "_div0"}, bus.rsp_div0, 0);
    check({tag, "_timeout"}, bus.rsp_timeout, 0);
  endtask

  // Issues a request from a negedge in IDLE. For a nonzero divisor it returns at
  // the negedge of the first WAIT_END cycle; for a zero divisor, in the first RESP cycle.
  task automatic send_req(input logic [7:0] a, input logic [7:0] b);
    check("idle_req_ready", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_dividend = 8'($urandom);
    bus.req_divisor  = 8'($urandom);
    check("busy_req_ready", bus.req_ready, 0);
    if (b != 8'd0) begin
      check("begin_high", core_begin, 1);
      check("inbus_dividend", core_inbus, a);
      core_end    = 1'b1;           // must be ignored outside WAIT_END
      core_outbus = 8'($urandom);
      @(negedge clk);
      core_end = 1'b0;
      check("begin_low", core_begin, 0);
      check("inbus_divisor", core_inbus, b);
      @(negedge clk);
      check("wait_inbus_zero", core_inbus, 0);
      check("wait_no_rsp", bus.rsp_valid, 0);
    end else begin
      check("div0_no_begin", core_begin, 0);
      check("div0_inbus_idle", core_inbus, 0);
    end
  endtask

  // Waits lat cycles in WAIT_END, then plays the core's end/quotient/remainder sequence.
  task automatic core_reply(input logic [7:0] q, input logic [7:0] r, input int lat);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("wait_rsp_low", bus.rsp_valid, 0);
      check("wait_no_timeout", bus.rsp_timeout, 0);
    end
    core_end    = 1'b1;
    core_outbus = q;
    @(negedge clk);
    core_end    = 1'b0;
    core_outbus = r;
    check("getrem_rsp_low", bus.rsp_valid, 0);
    @(negedge clk);
    core_outbus = 8'($urandom);
  endtask

  // Checks the response held for hold stalled cycles, then completes the handshake.
  task automatic take_rsp(input logic [7:0] q, input logic [7:0] r, input logic d0,
                          input logic tmo, input int hold);
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_quotient", bus.rsp_quotient, q);
    check("rsp_remainder", bus.rsp_remainder, r);
    check("rsp_div0", bus.rsp_div0, d0);
    check("rsp_timeout", bus.rsp_timeout, tmo);
    check("rsp_core_idle", core_begin, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_quotient", bus.rsp_quotient, q);
      check("hold_remainder", bus.rsp_remainder, r);
      check("hold_div0", bus.rsp_div0, d0);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_req_ready", bus.req_ready, 1);
    check("post_div0_clear", bus.rsp_div0, 0);
    check("post_timeout_clear", bus.rsp_timeout, 0);
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int lat, input int hold);
    logic [7:0] q, r;
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    send_req(a, b);
    if (b != 8'd0) core_reply(q, r, lat);
    take_rsp(q, r, b == 8'd0, 1'b0, hold);
  endtask

  initial begin
    rst_b            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;
    core_outbus      = '0;
    core_end         = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    run_div(8'd216, 8'd21, 2, 0);
    run_div(8'd100, 8'd0, 0, 0);
    run_div(8'd7, 8'd9, 1, 5);

`ifdef SRT4_ADAPTER_TIMEOUT_EN
    send_req(8'd40, 8'd3);
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      check("tmo_not_yet", bus.rsp_valid, 0);
    end
    @(negedge clk);
    take_rsp(8'd0, 8'd0, 1'b0, 1'b1, 1);
`else
    send_req(8'd40, 8'd3);
    core_reply(8'd13, 8'd1, 3 * TMO);
    take_rsp(8'd13, 8'd1, 1'b0, 1'b0, 0);
`endif

    // Asynchronous reset in the middle of WAIT_END aborts the transaction.
    send_req(8'd123, 8'd4);
    #2 rst_b = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_b       = 1'b1;
    core_end    = 1'b1;
    core_outbus = 8'd30;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_end = 1'b0;
      check("abort_no_rsp", bus.rsp_valid, 0);
      check("abort_ready", bus.req_ready, 1);
    end
    run_div(8'd50, 8'd5, 0, 0);

    run_div(8'd255, 8'd1, 0, 0);
    run_div(8'd200, 8'd13, 3, 0);

    for (int k = 0; k < 20; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_div(a, b, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
